// File: rtl/mux_nch_reg.sv
// mux_nch_reg: N-channel valid/ready multiplexer with registered output, fixed or round-robin select
//   i_clk, i_rst          clock, async active-high reset
//   i_mode, i_sel         0 = fixed select by i_sel, 1 = round-robin among valid channels
//   i_data, i_valid       packed channel data (channel k at [k*WIDTH +: WIDTH]) and per-channel valid
//   o_ready               per-channel ready, combinational
//   o_data, o_ch, o_valid registered output beat and the channel it came from
//   i_ready               downstream ready
module mux_nch_reg #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_mode,
  input  logic [SEL_W-1:0]        i_sel,
  input  logic [NUM_CH*WIDTH-1:0] i_data,
  input  logic [NUM_CH-1:0]       i_valid,
  output logic [NUM_CH-1:0]       o_ready,
  output logic [WIDTH-1:0]        o_data,
  output logic [SEL_W-1:0]        o_ch,
  output logic                    o_valid,
  input  logic                    i_ready
);
  logic [WIDTH-1:0] r_data;
  logic [SEL_W-1:0] r_ch;
  logic             r_valid;
  logic [SEL_W-1:0] r_ptr;
  logic             w_load;
  logic             w_fx_ok;
  logic             w_rr_found;
  logic [SEL_W-1:0] w_rr_g;
  logic [SEL_W-1:0] w_g;
  logic             w_gnt;
  logic             w_xfer;
  logic [WIDTH-1:0] w_data;
  int               w_dist;
  int               w_best;
  assign w_load  = !r_valid || i_ready;
  assign w_fx_ok = int'(i_sel) < NUM_CH;
  // Round-robin: the valid channel closest to r_ptr in circular order (wrapping at NUM_CH) wins
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_g     = '0;
    w_best     = NUM_CH;
    w_dist     = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_dist = (k >= int'(r_ptr)) ? k - int'(r_ptr) : k + NUM_CH - int'(r_ptr);
      if (i_valid[k] && w_dist < w_best) begin
        w_best     = w_dist;
        w_rr_found = 1'b1;
        w_rr_g     = SEL_W'(k);
      end
    end
  end
  assign w_g     = i_mode ? w_rr_g : i_sel;
  assign w_gnt   = i_mode ? w_rr_found : w_fx_ok;
  assign o_ready = (w_load && w_gnt && !i_rst) ? NUM_CH'(1) << w_g : '0;
  assign w_xfer  = |(o_ready & i_valid);
  // Constant-index mux so only the granted channel's data reaches the register
  always_comb begin
    w_data = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (w_g == SEL_W'(k)) w_data = i_data[k*WIDTH +: WIDTH];
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data  <= '0;
      r_ch    <= '0;
      r_valid <= 1'b0;
      r_ptr   <= '0;
    end else begin
      if (w_load) r_valid <= w_xfer;
      if (w_xfer) begin
        r_data <= w_data;
        r_ch   <= w_g;
      end
      if (w_xfer && i_mode) r_ptr <= (int'(w_g) == NUM_CH - 1) ? '0 : w_g + SEL_W'(1);
    end
  end
  assign o_data  = r_data;
  assign o_ch    = r_ch;
  assign o_valid = r_valid;
endmodule
